glyph_column_decoder: RTL and testbench

Column-stream reader for the 5x5 name-display font. Accepts one 5-bit column per valid cycle, frames columns into 5-column glyphs separated by one blank column, and matches each glyph against the font table. For each glyph it emits a one-cycle ASCII code pulse, plus error flags for unknown glyphs and missing gaps. It sits on the receive side of the column pattern driver and recovers the characters (M, E, N, A, K, S, H, I) from the column stream.

---
 rtl/glyph_font_pkg.sv | 34 +++
 rtl/glyph_match.sv | 26 ++
 rtl/glyph_column_decoder.sv | 117 +++++++++++
 tb/tb_glyph_column_decoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_font_pkg.sv
// Shared font definitions for the 5x5 column glyph decoder: geometry,
// glyph bitmaps (column 0 in the MSBs), ASCII codes and FSM encoding.
package glyph_font_pkg;

  localparam int GLYPH_COLS = 5;
  localparam int COL_W      = 5;
  localparam int GLYPH_W    = GLYPH_COLS * COL_W;

  localparam logic [GLYPH_W-1:0] GLYPH_M = 25'b11111_11000_00100_11000_11111;
  localparam logic [GLYPH_W-1:0] GLYPH_E = 25'b11111_10101_10101_10001_10001;
  localparam logic [GLYPH_W-1:0] GLYPH_N = 25'b11111_10000_11111_00001_11111;
  localparam logic [GLYPH_W-1:0] GLYPH_A = 25'b11111_10100_10100_10100_11111;
  localparam logic [GLYPH_W-1:0] GLYPH_K = 25'b11111_00100_00100_01010_10001;
  localparam logic [GLYPH_W-1:0] GLYPH_S = 25'b11101_10101_10101_10101_10111;
  localparam logic [GLYPH_W-1:0] GLYPH_H = 25'b11111_00100_00100_00100_11111;
  localparam logic [GLYPH_W-1:0] GLYPH_I = 25'b10001_10001_11111_10001_10001;

  localparam logic [7:0] ASCII_M       = 8'h4D;
  localparam logic [7:0] ASCII_E       = 8'h45;
  localparam logic [7:0] ASCII_N       = 8'h4E;
  localparam logic [7:0] ASCII_A       = 8'h41;
  localparam logic [7:0] ASCII_K       = 8'h4B;
  localparam logic [7:0] ASCII_S       = 8'h53;
  localparam logic [7:0] ASCII_H       = 8'h48;
  localparam logic [7:0] ASCII_I       = 8'h49;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_GAP     = 2'd2
  } state_e;

endpackage

// File: rtl/glyph_match.sv
// Combinational font lookup: 25-bit glyph bitmap in, hit flag and ASCII out.
module glyph_match
  import glyph_font_pkg::*;
(
  input  logic [GLYPH_W-1:0] glyph,
  output logic               hit,
  output logic [7:0]         code
);

  always_comb begin
    hit  = 1'b1;
    code = ASCII_UNKNOWN;
    case (glyph)
      GLYPH_M: code = ASCII_M;
      GLYPH_E: code = ASCII_E;
      GLYPH_N: code = ASCII_N;
      GLYPH_A: code = ASCII_A;
      GLYPH_K: code = ASCII_K;
      GLYPH_S: code = ASCII_S;
      GLYPH_H: code = ASCII_H;
      GLYPH_I: code = ASCII_I;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/glyph_column_decoder.sv
// Frames a column stream into 5-column glyphs separated by blank columns and
// emits one registered ASCII pulse per glyph, with unknown-glyph and gap errors.
module glyph_column_decoder
  import glyph_font_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             col_valid,
  input  logic [COL_W-1:0] col,
  output logic             char_valid,
  output logic [7:0]       char_code,
  output logic             char_err,
  output logic             frame_err,
  output logic             busy,
  output logic [7:0]       glyph_count
);

  state_e               state_q, state_d;
  logic [2:0]           col_cnt_q, col_cnt_d;
  logic [GLYPH_W-1:0]   glyph_q, glyph_d;
  logic                 char_valid_q, char_valid_d;
  logic [7:0]           char_code_q, char_code_d;
  logic                 char_err_q, char_err_d;
  logic                 frame_err_q, frame_err_d;
  logic [7:0]           glyph_count_q, glyph_count_d;

  logic [GLYPH_W-1:0]   full_glyph;
  logic                 match_hit;
  logic [7:0]           match_code;

  // Columns shift in from the LSB end so column 0 lands in the MSBs.
  assign full_glyph = {glyph_q[GLYPH_W-COL_W-1:0], col};

  glyph_match u_match (
    .glyph (full_glyph),
    .hit   (match_hit),
    .code  (match_code)
  );

  always_comb begin
    state_d       = state_q;
    col_cnt_d     = col_cnt_q;
    glyph_d       = glyph_q;
    char_valid_d  = 1'b0;
    char_code_d   = char_code_q;
    char_err_d    = 1'b0;
    frame_err_d   = 1'b0;
    glyph_count_d = glyph_count_q;

    if (col_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (col != '0) begin
            glyph_d   = {{(GLYPH_W-COL_W){1'b0}}, col};
            col_cnt_d = 3'd1;
            state_d   = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          glyph_d = full_glyph;
          if (col_cnt_q == 3'(GLYPH_COLS - 1)) begin
            char_valid_d  = 1'b1;
            char_code_d   = match_hit ? match_code : ASCII_UNKNOWN;
            char_err_d    = ~match_hit;
            glyph_count_d = glyph_count_q + 8'd1;
            col_cnt_d     = 3'd0;
            state_d       = ST_GAP;
          end else begin
            col_cnt_d = col_cnt_q + 3'd1;
          end
        end
        ST_GAP: begin
          if (col == '0) begin
            state_d = ST_IDLE;
          end else begin
            // Missing gap: flag it but keep the column as the next glyph's start.
            frame_err_d = 1'b1;
            glyph_d     = {{(GLYPH_W-COL_W){1'b0}}, col};
            col_cnt_d   = 3'd1;
            state_d     = ST_COLLECT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      col_cnt_q     <= '0;
      glyph_q       <= '0;
      char_valid_q  <= 1'b0;
      char_code_q   <= 8'h00;
      char_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      glyph_count_q <= '0;
    end else begin
      state_q       <= state_d;
      col_cnt_q     <= col_cnt_d;
      glyph_q       <= glyph_d;
      char_valid_q  <= char_valid_d;
      char_code_q   <= char_code_d;
      char_err_q    <= char_err_d;
      frame_err_q   <= frame_err_d;
      glyph_count_q <= glyph_count_d;
    end
  end

  assign char_valid  = char_valid_q;
  assign char_code   = char_code_q;
  assign char_err    = char_err_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != ST_IDLE);
  assign glyph_count = glyph_count_q;

endmodule

// File: tb/tb_glyph_column_decoder.sv
// Randomised scoreboard bench for glyph_column_decoder against a queue-based
// reference model with a bitmap->ASCII font dictionary.
module tb_glyph_column_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       col_valid;
  logic [4:0] col;
  logic       char_valid;
  logic [7:0] char_code;
  logic       char_err;
  logic       frame_err;
  logic       busy;
  logic [7:0] glyph_count;

  glyph_column_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .col_valid   (col_valid),
    .col         (col),
    .char_valid  (char_valid),
    .char_code   (char_code),
    .char_err    (char_err),
    .frame_err   (frame_err),
    .busy        (busy),
    .glyph_count (glyph_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       err;
    logic [7:0] cnt;
    int         tag;
  } exp_t;

  exp_t       cq[$];
  int         fq[$];
  int         checks   = 0;
  int         failures = 0;
  int         edge_cnt = 0;

  // Reference model state
  logic [24:0] glyphs[8];
  logic [7:0]  codes[8];
  logic [7:0]  font[logic [24:0]];
  int          mode;          // 0 idle, 1 collecting, 2 expecting gap
  logic [4:0]  mbuf[$];
  logic [7:0]  mcount;
  logic [7:0]  last_code;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic start_glyph(input logic [4:0] c);
    mbuf.delete();
    mbuf.push_back(c);
    mode = 1;
  endtask

  task automatic model_col(input logic [4:0] c);
    exp_t e;
    logic [24:0] g;
    if (mode == 2) begin
      if (c == 5'd0) mode = 0;
      else begin
        fq.push_back(edge_cnt);
        start_glyph(c);
      end
    end else if (mode == 1) begin
      mbuf.push_back(c);
      if (mbuf.size() == 5) begin
        g = {mbuf[0], mbuf[1], mbuf[2], mbuf[3], mbuf[4]};
        mcount = mcount + 8'd1;
        e.code = font.exists(g) ? font[g] : 8'h3F;
        e.err  = !font.exists(g);
        e.cnt  = mcount;
        e.tag  = edge_cnt;
        cq.push_back(e);
        mbuf.delete();
        mode = 2;
      end
    end else if (c != 5'd0) begin
      start_glyph(c);
    end
  endtask

  task automatic send(input logic v, input logic [4:0] c);
    col_valid = v;
    col       = c;
    @(posedge clk);
    #1;
    col_valid = 1'b0;
    if (v) model_col(c);
    chk("busy", {31'd0, busy}, {31'd0, (mode != 0)});
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 5'd0);
  endtask

  task automatic send_glyph(input logic [24:0] g, input bit gap, input int stall);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, g[24-5*i -: 5]);
      if (i < 4) idle(stall);
    end
    if (gap) send(1'b1, 5'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    col_valid = 1'b1;
    col       = 5'h1F;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    col_valid = 1'b0;
    col       = 5'd0;
    mode      = 0;
    mbuf.delete();
    mcount    = 8'd0;
    last_code = 8'h00;
    cq.delete();
    fq.delete();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    exp_t e;
    if (char_valid) begin
      if (cq.size() == 0) chk("char_unexpected", 32'd1, 32'd0);
      else begin
        e = cq.pop_front();
        chk("char_latency", edge_cnt, e.tag);
        chk("char_code", {24'd0, char_code}, {24'd0, e.code});
        chk("char_err", {31'd0, char_err}, {31'd0, e.err});
        chk("glyph_count", {24'd0, glyph_count}, {24'd0, e.cnt});
        last_code = e.code;
      end
    end else begin
      if (char_err) chk("char_err_idle", 32'd1, 32'd0);
      chk("char_code_hold", {24'd0, char_code}, {24'd0, last_code});
    end
    if (cq.size() != 0 && cq[0].tag < edge_cnt) begin
      chk("char_missed", 32'd0, 32'd1);
      void'(cq.pop_front());
    end
    if (frame_err) begin
      if (fq.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
      else chk("frame_latency", edge_cnt, fq.pop_front());
    end
    if (fq.size() != 0 && fq[0] < edge_cnt) begin
      chk("frame_missed", 32'd0, 32'd1);
      void'(fq.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[9];
    glyphs[0] = 25'b11111_11000_00100_11000_11111; codes[0] = 8'h4D; // M
    glyphs[1] = 25'b11111_10101_10101_10001_10001; codes[1] = 8'h45; // E
    glyphs[2] = 25'b11111_10000_11111_00001_11111; codes[2] = 8'h4E; // N
    glyphs[3] = 25'b11111_10100_10100_10100_11111; codes[3] = 8'h41; // A
    glyphs[4] = 25'b11111_00100_00100_01010_10001; codes[4] = 8'h4B; // K
    glyphs[5] = 25'b11101_10101_10101_10101_10111; codes[5] = 8'h53; // S
    glyphs[6] = 25'b11111_00100_00100_00100_11111; codes[6] = 8'h48; // H
    glyphs[7] = 25'b10001_10001_11111_10001_10001; codes[7] = 8'h49; // I
    for (int i = 0; i < 8; i++) font[glyphs[i]] = codes[i];

    rst = 1'b1; col_valid = 1'b0; col = 5'd0;
    mode = 0; mcount = 8'd0; last_code = 8'h00;
    @(posedge clk);
    do_reset();
    chk("rst_char_valid", {31'd0, char_valid}, 32'd0);
    chk("rst_char_code", {24'd0, char_code}, 32'h00);
    chk("rst_char_err", {31'd0, char_err}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_glyph_count", {24'd0, glyph_count}, 32'd0);

    // MEENAKSHI, continuous valid
    seq = '{0, 1, 1, 2, 3, 4, 5, 6, 7};
    for (int i = 0; i < 9; i++) send_glyph(glyphs[seq[i]], 1'b1, 0);
    idle(3);
    chk("meenakshi_count", {24'd0, glyph_count}, 32'd9);
    chk("meenakshi_last", {24'd0, char_code}, 32'h49);

    // Unknown glyph
    do_reset();
    send_glyph(25'b11111_10001_10001_10001_11111, 1'b1, 0);
    idle(3);
    chk("unknown_code", {24'd0, char_code}, 32'h3F);
    chk("unknown_count", {24'd0, glyph_count}, 32'd1);

    // H immediately followed by I
    do_reset();
    send_glyph(glyphs[6], 1'b0, 0);
    send_glyph(glyphs[7], 1'b1, 0);
    idle(3);
    chk("hi_count", {24'd0, glyph_count}, 32'd2);
    chk("hi_last", {24'd0, char_code}, 32'h49);

    // M with 3 stall cycles between columns
    do_reset();
    send_glyph(glyphs[0], 1'b1, 3);
    idle(3);
    chk("stall_code", {24'd0, char_code}, 32'h4D);

    // Partial E, reset, then A
    do_reset();
    for (int i = 0; i < 3; i++) send(1'b1, glyphs[1][24-5*i -: 5]);
    do_reset();
    send_glyph(glyphs[3], 1'b1, 0);
    idle(3);
    chk("partial_count", {24'd0, glyph_count}, 32'd1);
    chk("partial_code", {24'd0, char_code}, 32'h41);

    // Leading zero columns, then K
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b1, 5'd0);
    chk("zeros_busy", {31'd0, busy}, 32'd0);
    send_glyph(glyphs[4], 1'b1, 0);
    idle(3);
    chk("k_code", {24'd0, char_code}, 32'h4B);

    // Randomised stream
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r < 8) send_glyph(glyphs[r], ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
      else if (r == 8) send_glyph(25'($urandom), ($urandom_range(0, 1) != 0), 0);
      else if (r == 9) send(1'b1, 5'($urandom));
      else if (r == 10) idle($urandom_range(1, 3));
      else if ($urandom_range(0, 7) == 0) do_reset();
      else send(1'b1, 5'd0);
    end
    idle(4);
    chk("final_count", {24'd0, glyph_count}, {24'd0, mcount});
    chk("char_q_empty", cq.size(), 32'd0);
    chk("frame_q_empty", fq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
